mult_div_seq: RTL

//   Parametrised multi-cycle multiply/divide unit; successor to the fixed 16x16 mult.

---
 rtl/mult_div_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mult_div_seq.sv
// Multi-cycle multiply/divide unit: iterative shift-add multiply and restoring
// divide, signed or unsigned, with a start/busy/done handshake.
module mult_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only while busy=0 (state IDLE); busy is high
  // from the edge that accepts start until the edge that raises done; done is a
  // one-cycle pulse and results/div_by_zero are valid from that cycle on.

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t state, state_nxt;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_res, neg_rem, dz_q;

  logic               is_div, is_signed, a_neg, b_neg, b_zero, last;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum, partial, trial;
  logic               ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo_f, rem_f;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign abs_a     = a_neg ? -a_q : a_q;
  assign abs_b     = b_neg ? -b_q : b_q;
  assign b_zero    = (b_q == '0);
  assign last      = (cnt == CW'(WIDTH - 1));

  // Multiply step: multiplier sits in the low half and drains out to the right.
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_b};
  assign mul_next = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Divide step: partial remainder can briefly need WIDTH+1 bits after the shift.
  assign partial  = acc[2*WIDTH-1:WIDTH-1];
  assign trial    = partial - {1'b0, mag_b};
  assign ge       = partial[WIDTH] | ~trial[WIDTH];
  assign div_next = ge ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                       : {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign prod  = neg_res ? -acc : acc;
  assign quo_f = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_f = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = (is_div && b_zero) ? FIX : RUN;
      RUN:     if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz_q        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        PREP: begin
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          mag_b   <= abs_b;
          acc     <= {{WIDTH{1'b0}}, abs_a};
          cnt     <= '0;
          dz_q    <= is_div & b_zero;
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz_q;
          if (dz_q) begin
            result_lo <= '1;
            result_hi <= a_q;
          end else if (is_div) begin
            result_lo <= quo_f;
            result_hi <= rem_f;
          end else begin
            result_lo <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
